// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multicycle signed multiply/divide unit for the MIPS multicycle datapath.
// The control unit starts an operation with MultControl (mult_start) or
// DivControl (div_start) and waits while busy is high. Results land in the
// Hi/Lo registers read by mfhi/mflo. Internally the unit works on unsigned
// magnitudes and applies sign correction in a final FIX state:
//   IDLE -> MULT | DIV (WIDTH steps, one per clock) -> FIX -> IDLE
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high reset
//   mult_start  in   1      start signed a*b; sampled only in IDLE (wins over div)
//   div_start   in   1      start signed a/b; sampled only in IDLE
//   a           in   WIDTH  operand A / dividend, captured on the start edge
//   b           in   WIDTH  operand B / divisor, captured on the start edge
//   busy        out  1      operation in progress
//   done        out  1      one-cycle pulse; hi/lo valid from this cycle
//   hi          out  WIDTH  product upper half / remainder
//   lo          out  WIDTH  product lower half / quotient
//   div_zero    out  1      divide-by-zero flag, valid with done
//
// Configuration
//   DIV_ZERO_EXC_EN  when defined, divide by zero skips iteration, raises
//                    div_zero with done one edge after the start and leaves
//                    hi/lo untouched. When undefined, div_zero is tied low and
//                    divide by zero runs the full latency with hi = a and
//                    lo = all ones.
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MULT = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    // State and datapath registers
    logic [1:0]         state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    // Multiply: {partial product high, multiplier / product low}
    // Divide:   {remainder, dividend / quotient}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiply: |a| (multiplicand). Divide: |b| (divisor).
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               is_div_q, is_div_d;
    logic               neg_res_q, neg_res_d;  // sign(a) ^ sign(b)
    logic               neg_a_q, neg_a_d;      // remainder follows sign(a)
    logic               bzero_q, bzero_d;      // divide with b == 0
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    // Operand magnitudes. Unsigned result makes |-2^(WIDTH-1)| exact.
    logic [WIDTH-1:0] abs_a, abs_b;
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    logic start_any;
    assign start_any = mult_start | div_start;

    // Shift-add multiply step. The adder carry becomes the new MSB after the
    // right shift, so no product bit is lost.
    logic [WIDTH-1:0]   add_in;
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] mult_next;
    assign add_in    = acc_q[0] ? opnd_q : '0;
    assign mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, add_in};
    assign mult_next = {mult_sum, acc_q[WIDTH-1:1]};

    // Restoring divide step. shifted = {remainder, next dividend bit}; the
    // trial difference is negative exactly when its top bit is set because
    // the remainder is always below the divisor.
    logic [WIDTH:0]     div_shifted;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    assign div_shifted = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_trial   = div_shifted - {1'b0, opnd_q};
    always_comb begin
        div_next = '0;
        if (!div_trial[WIDTH]) begin
            div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
            div_next = {div_shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign-corrected results
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    assign prod_fix = neg_res_q ? -acc_q : acc_q;
    assign quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef DIV_ZERO_EXC_EN
    logic dz_q, dz_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        bzero_d   = bzero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
`ifdef DIV_ZERO_EXC_EN
        dz_d      = dz_q;
`endif

        case (state_q)
            IDLE: begin
                if (start_any) begin
                    // Multiply has priority when both strobes are high
                    is_div_d  = ~mult_start;
                    neg_res_d = a[WIDTH-1] ^ b[WIDTH-1];
                    neg_a_d   = a[WIDTH-1];
                    bzero_d   = ~mult_start & (b == '0);
                    cnt_d     = CntW'(WIDTH);
`ifdef DIV_ZERO_EXC_EN
                    dz_d      = 1'b0;
`endif
                    if (mult_start) begin
                        opnd_d  = abs_a;
                        acc_d   = {{WIDTH{1'b0}}, abs_b};
                        state_d = MULT;
                    end else begin
                        opnd_d  = abs_b;
                        acc_d   = {{WIDTH{1'b0}}, abs_a};
                        state_d = DIV;
`ifdef DIV_ZERO_EXC_EN
                        if (b == '0) begin
                            state_d = FIX;
                        end
`endif
                    end
                end
            end

            MULT: begin
                acc_d = mult_next;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = FIX;
                end
            end

            DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else begin
`ifdef DIV_ZERO_EXC_EN
                    if (bzero_q) begin
                        // Hi/Lo are left alone; the control unit traps instead
                        dz_d = 1'b1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
`else
                    // With a zero divisor every trial subtract succeeds, so the
                    // remainder ends as |a| and its sign fix restores hi = a.
                    hi_d = rem_fix;
                    lo_d = bzero_q ? {WIDTH{1'b1}} : quot_fix;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
            bzero_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
            bzero_q   <= bzero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

`ifdef DIV_ZERO_EXC_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end
    assign div_zero = dz_q;
`else
    assign div_zero = 1'b0;
`endif

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Directed self-checking bench for mult_div_unit (WIDTH = 32). Each step drives
// a start on a falling edge, then counts rising edges until done and compares
// latency, flags and Hi/Lo against hand-computed values. Honours
// DIV_ZERO_EXC_EN for the divide-by-zero expectations.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [31:0] hold_hi, hold_lo;

    mult_div_unit #(
        .WIDTH(32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mult_start(mult_start),
        .div_start (div_start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a start for exactly one rising edge (E0); returns 1 ns after E0.
    task automatic start(input logic m, input logic d, input logic [31:0] av,
                         input logic [31:0] bv);
        @(negedge clk);
        mult_start = m;
        div_start  = d;
        a          = av;
        b          = bv;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = 32'hDEAD_BEEF;
        b          = 32'h0000_0000;
    endtask

    // Count rising edges until done is seen; -1 if it never arrives.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 100 && edges < 0; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) edges = i;
        end
    endtask

    task automatic check_quiet(input int n, input string tag);
        int pulses;
        pulses = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        chk(tag, 32'(pulses), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        a          = '0;
        b          = '0;

        // Reset state
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1: 7 * -3 = -21
        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("m1_busy", {31'd0, busy}, 32'd1);
        chk("m1_hold_lo", lo, 32'd0);
        wait_done(lat);
        chk("m1_lat", 32'(lat), 32'd33);
        chk("m1_busy_done", {31'd0, busy}, 32'd0);
        chk("m1_hi", hi, 32'hFFFF_FFFF);
        chk("m1_lo", lo, 32'hFFFF_FFEB);
        @(posedge clk);
        #1;
        chk("m1_done_pulse", {31'd0, done}, 32'd0);

        // 2: -7 / 2 = -3 r -1 ; 7 / -2 = -3 r 1 (back-to-back)
        start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done(lat);
        chk("d1_lat", 32'(lat), 32'd33);
        chk("d1_lo", lo, 32'hFFFF_FFFD);
        chk("d1_hi", hi, 32'hFFFF_FFFF);
        start(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE);
        wait_done(lat);
        chk("d2_lat", 32'(lat), 32'd33);
        chk("d2_lo", lo, 32'hFFFF_FFFD);
        chk("d2_hi", hi, 32'd1);

        // 3: overflow divide and most-negative square
        start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        chk("d3_lo", lo, 32'h8000_0000);
        chk("d3_hi", hi, 32'd0);
        chk("d3_dz", {31'd0, div_zero}, 32'd0);
        start(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done(lat);
        chk("m3_hi", hi, 32'h4000_0000);
        chk("m3_lo", lo, 32'd0);

        // 4: divide by zero
        start(1'b0, 1'b1, 32'd5, 32'd0);
        wait_done(lat);
`ifdef DIV_ZERO_EXC_EN
        chk("dz_lat", 32'(lat), 32'd1);
        chk("dz_flag", {31'd0, div_zero}, 32'd1);
        chk("dz_hi", hi, 32'h4000_0000);
        chk("dz_lo", lo, 32'd0);
        hold_hi = 32'h4000_0000;
        hold_lo = 32'd0;
`else
        chk("dz_lat", 32'(lat), 32'd33);
        chk("dz_flag", {31'd0, div_zero}, 32'd0);
        chk("dz_hi", hi, 32'd5);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        hold_hi = 32'd5;
        hold_lo = 32'hFFFF_FFFF;
`endif

        // 5a: div_start mid-multiply is ignored
        start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        chk("i1_dz_clr", {31'd0, div_zero}, 32'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        div_start = 1'b1;
        a         = 32'd100;
        b         = 32'd9;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        chk("i1_busy", {31'd0, busy}, 32'd1);
        chk("i1_hold_hi", hi, hold_hi);
        chk("i1_hold_lo", lo, hold_lo);
        wait_done(lat);
        chk("i1_lat", 32'(lat + 10), 32'd33);
        chk("i1_hi", hi, 32'hFFFF_FFFF);
        chk("i1_lo", lo, 32'hFFFF_FFEB);
        check_quiet(40, "i1_extra_done");

        // 5b: both strobes together -> multiply only
        start(1'b1, 1'b1, 32'd3, 32'd5);
        wait_done(lat);
        chk("i2_lat", 32'(lat), 32'd33);
        chk("i2_hi", hi, 32'd0);
        chk("i2_lo", lo, 32'd15);
        check_quiet(40, "i2_extra_done");

        // 6: asynchronous reset mid-divide
        start(1'b0, 1'b1, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_busy", {31'd0, busy}, 32'd0);
        chk("ar_done", {31'd0, done}, 32'd0);
        chk("ar_hi", hi, 32'd0);
        chk("ar_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start(1'b1, 1'b0, 32'd3, 32'd4);
        wait_done(lat);
        chk("ar_m_lat", 32'(lat), 32'd33);
        chk("ar_m_hi", hi, 32'd0);
        chk("ar_m_lo", lo, 32'd12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
